serial_checksum_receiver: RTL

//  Byte-serial receive end of the 8-bit checksum link. Accepts frames of DATA_BYTES data bytes

---
 rtl/serial_checksum_receiver_pkg.sv | 17 +
 rtl/serial_checksum_receiver.sv | 101 ++++++++++
 2 files changed

// File: rtl/serial_checksum_receiver_pkg.sv
// Shared checksum-link definitions: byte width, default frame geometry and the 8-bit running sum.
package serial_checksum_receiver_pkg;
   localparam int unsigned CSUM_W          = 8;
   localparam int unsigned DEF_DATA_BYTES  = 4;
   localparam int unsigned FRAME_BYTES     = DEF_DATA_BYTES + 1;

   typedef enum logic {
      COLLECT,
      CSUM
   } rx_state_e;

   // Running modulo-256 sum; a frame is good when the sum over all its bytes is zero.
   function automatic logic [CSUM_W-1:0] csum8(input logic [CSUM_W-1:0] acc,
                                               input logic [CSUM_W-1:0] b);
      return acc + b;
   endfunction
endpackage

// File: rtl/serial_checksum_receiver.sv
// Byte-serial checksum link receiver: reassembles {data, csum} frames and flags them good/bad.
module serial_checksum_receiver
   import serial_checksum_receiver_pkg::*;
#(
   parameter int unsigned DATA_BYTES = DEF_DATA_BYTES,
   parameter int unsigned ERR_W      = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic [CSUM_W-1:0]                ip,
   input  logic                             ip_valid,
   output logic                             ip_ready,
   output logic [CSUM_W*(DATA_BYTES+1)-1:0] op,
   output logic                             op_valid,
   input  logic                             op_ready,
   output logic                             checksum_valid,
   output logic [ERR_W-1:0]                 err_count
);

   localparam int unsigned SH_W   = CSUM_W * DATA_BYTES;
   localparam int unsigned OP_W   = CSUM_W * (DATA_BYTES + 1);
   localparam int unsigned CNT_W  = $clog2(DATA_BYTES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);

   rx_state_e           state_q;
   logic [CNT_W-1:0]    byte_cnt_q;
   logic [CSUM_W-1:0]   acc_q;
   logic [SH_W-1:0]     shift_q;
   logic [OP_W-1:0]     op_q;
   logic                op_valid_q;
   logic                csum_ok_q;
   logic [ERR_W-1:0]    err_q;

   logic                accept;
   logic [CSUM_W-1:0]   acc_d;
   logic [SH_W-1:0]     shift_d;
   logic [OP_W-1:0]     frame_d;

   assign ip_ready = ~op_valid_q | op_ready;
   assign accept   = ip_valid & ip_ready & ~flush;

   always_comb begin
      acc_d   = csum8(acc_q, ip);
      frame_d = {shift_q, ip};
      shift_d = SH_W'(frame_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= COLLECT;
         byte_cnt_q <= '0;
         acc_q      <= '0;
         shift_q    <= '0;
         op_q       <= '0;
         op_valid_q <= 1'b0;
         csum_ok_q  <= 1'b0;
         err_q      <= '0;
      end else begin
         // Consumption first; a frame completing this cycle overrides it below.
         if (op_valid_q && op_ready) begin
            op_valid_q <= 1'b0;
         end
         if (flush) begin
            state_q    <= COLLECT;
            byte_cnt_q <= '0;
            acc_q      <= '0;
            shift_q    <= '0;
         end else if (accept) begin
            shift_q <= shift_d;
            unique case (state_q)
               COLLECT: begin
                  acc_q      <= acc_d;
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  if (byte_cnt_q == CNT_LAST) begin
                     state_q <= CSUM;
                  end
               end
               CSUM: begin
                  op_q       <= frame_d;
                  op_valid_q <= 1'b1;
                  csum_ok_q  <= (acc_d == '0);
                  if ((acc_d != '0) && (err_q != '1)) begin
                     err_q <= err_q + 1'b1;
                  end
                  acc_q      <= '0;
                  byte_cnt_q <= '0;
                  state_q    <= COLLECT;
               end
               default: state_q <= COLLECT;
            endcase
         end
      end
   end

   assign op             = op_q;
   assign op_valid       = op_valid_q;
   assign checksum_valid = csum_ok_q;
   assign err_count      = err_q;

endmodule
